// File: rtl/toast_imem_responder.sv
// rtl/toast_imem_responder.sv - word-addressed IMEM responder with byte-serial program loader
// Registered one-cycle fetch; the loader owns the array whenever its FSM is not IDLE.
module toast_imem_responder #(
   parameter int          REG_DATA_WIDTH  = 32,
   parameter int          IMEM_ADDR_WIDTH = 32,
   parameter int          DEPTH_WORDS     = 1024,
   parameter logic [31:0] LOAD_BASE       = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [IMEM_ADDR_WIDTH-1:0] IMEM_addr_i,
   input  logic                       IMEM_ce_i,
   input  logic                       IMEM_we_i,
   input  logic [REG_DATA_WIDTH-1:0]  IMEM_d_i,
   output logic [REG_DATA_WIDTH-1:0]  IMEM_data_o,
   input  logic                       load_en_i,
   input  logic                       load_valid_i,
   input  logic [7:0]                 load_byte_i,
   output logic                       load_ready_o,
   output logic                       load_busy_o,
   output logic [15:0]                load_words_o,
   output logic                       load_ovf_o,
   output logic                       addr_err_o
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int IW = IMEM_ADDR_WIDTH - 2;
   localparam logic [AW-1:0] BASE_IDX = AW'(LOAD_BASE >> 2);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

   state_t                    state, next_state;
   logic [REG_DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   logic [1:0]                byte_cnt, cnt_upd;
   logic [AW-1:0]             ptr;
   logic [23:0]               shreg;
   logic [REG_DATA_WIDTH-1:0] data_q;
   logic [15:0]               words;
   logic                      ovf, addr_err;

   logic [IW-1:0]             idx;
   logic                      in_range, accept;
   logic                      mem_we;
   logic [AW-1:0]             mem_waddr;
   logic [REG_DATA_WIDTH-1:0] mem_wdata;

   wire unused_addr_lsbs = &{1'b0, IMEM_addr_i[1:0]};

   assign idx          = IMEM_addr_i[IMEM_ADDR_WIDTH-1:2];
   assign in_range     = (idx[IW-1:AW] == '0);
   assign accept       = (state == LOAD) && load_valid_i && !ovf;
   assign IMEM_data_o  = data_q;
   assign load_ready_o = (state == LOAD) && !ovf;
   assign load_busy_o  = (state != IDLE);
   assign load_words_o = words;
   assign load_ovf_o   = ovf;
   assign addr_err_o   = addr_err;

   always_comb begin
      next_state = state;
      mem_we     = 1'b0;
      mem_waddr  = ptr;
      mem_wdata  = '0;
      cnt_upd    = byte_cnt;
      if (accept)
         cnt_upd = byte_cnt + 2'd1;
      case (state)
         IDLE: begin
            if (load_en_i)
               next_state = LOAD;
            if (IMEM_ce_i && IMEM_we_i && in_range) begin
               mem_we    = 1'b1;
               mem_waddr = idx[AW-1:0];
               mem_wdata = IMEM_d_i;
            end
         end
         LOAD: begin
            if (accept && byte_cnt == 2'd3) begin
               mem_we    = 1'b1;
               mem_wdata = REG_DATA_WIDTH'({load_byte_i, shreg});
            end
            // Exit decision uses the count after this cycle's byte is taken.
            if (!load_en_i)
               next_state = (cnt_upd != 2'd0) ? FLUSH : IDLE;
         end
         FLUSH: begin
            next_state = IDLE;
            mem_we     = !ovf;
            case (byte_cnt)
               2'd1:    mem_wdata = REG_DATA_WIDTH'(shreg[7:0]);
               2'd2:    mem_wdata = REG_DATA_WIDTH'(shreg[15:0]);
               2'd3:    mem_wdata = REG_DATA_WIDTH'(shreg[23:0]);
               default: mem_wdata = '0;
            endcase
         end
         default: next_state = IDLE;
      endcase
   end

   // Array is never reset, so preloaded words survive a reset.
   always_ff @(posedge clk_i) begin
      if (mem_we && !reset_i)
         mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state    <= IDLE;
         byte_cnt <= 2'd0;
         ptr      <= BASE_IDX;
         shreg    <= '0;
         data_q   <= '0;
         words    <= '0;
         ovf      <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         state    <= next_state;
         addr_err <= IMEM_ce_i && !in_range;
         if (IMEM_ce_i) begin
            if (state != IDLE)
               data_q <= REG_DATA_WIDTH'(NOP_INSTR);
            else if (!in_range)
               data_q <= '0;
            else
               data_q <= mem[idx[AW-1:0]];
         end
         case (state)
            IDLE: begin
               if (load_en_i) begin
                  ptr      <= BASE_IDX;
                  byte_cnt <= 2'd0;
                  words    <= '0;
                  ovf      <= 1'b0;
               end
            end
            LOAD: begin
               if (accept) begin
                  byte_cnt <= cnt_upd;
                  if (byte_cnt == 2'd3) begin
                     if (words != 16'hFFFF)
                        words <= words + 16'd1;
                     if (ptr == LAST_IDX)
                        ovf <= 1'b1;
                     else
                        ptr <= ptr + 1'b1;
                  end else begin
                     shreg[{byte_cnt, 3'b000} +: 8] <= load_byte_i;
                  end
               end
            end
            FLUSH: begin
               byte_cnt <= 2'd0;
               if (!ovf && words != 16'hFFFF)
                  words <= words + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
